// File: rtl/scpu_pkg.sv
// Shared sCPU definitions: register-file geometry and the load-tracker state encoding.
package scpu_pkg;

  localparam int DATA_W     = 8;
  localparam int REG_ADDR_W = 2;
  localparam int NUM_REGS   = 4;

  typedef enum logic {
    IDLE    = 1'b0,
    WAIT_LD = 1'b1
  } ld_state_t;

endpackage

// File: rtl/ld_tracker.sv
// Tracks the single outstanding multi-cycle load: FSM, pending destination, busy flags, ld_ready.
// Build option REG0_ZERO_EN: a load to register 0 never marks it busy.
module ld_tracker
  import scpu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ld_issue,
  input  logic [REG_ADDR_W-1:0] ld_rd,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  output logic [NUM_REGS-1:0]   busy,
  output logic [REG_ADDR_W-1:0] pend_rd,
  output logic                  ld_done,
  output ld_state_t             state
);

  ld_state_t             r_state;
  logic [REG_ADDR_W-1:0] r_pend_rd;
  logic [NUM_REGS-1:0]   r_busy;
  logic                  r_ld_ready;
  logic                  w_track;

`ifdef REG0_ZERO_EN
  assign w_track = (ld_rd != '0);
`else
  assign w_track = 1'b1;
`endif

  // Return handshake: data moves on the rising edge where ld_valid && ld_ready;
  // ld_ready is registered and held high for the whole WAIT_LD state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_pend_rd  <= '0;
      r_busy     <= '0;
      r_ld_ready <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (ld_issue) begin
            r_pend_rd     <= ld_rd;
            r_busy[ld_rd] <= w_track;
            r_ld_ready    <= 1'b1;
            r_state       <= WAIT_LD;
          end
        end
        WAIT_LD: begin
          if (ld_valid) begin
            r_busy[r_pend_rd] <= 1'b0;
            r_ld_ready        <= 1'b0;
            r_state           <= IDLE;
          end
        end
      endcase
    end
  end

  assign state    = r_state;
  assign pend_rd  = r_pend_rd;
  assign busy     = r_busy;
  assign ld_ready = r_ld_ready;
  assign ld_done  = ld_valid & r_ld_ready;

endmodule

// File: rtl/reg_file.sv
// Four-entry sCPU register file with ALU writeback, one tracked load and hazard stall.
// Build option REG0_ZERO_EN: register 0 reads as zero and ignores all writes.
module reg_file #(
  parameter int                   DATA_W    = scpu_pkg::DATA_W,
  parameter logic [DATA_W-1:0]    RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_we,
  input  logic [1:0]        alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              ld_issue,
  input  logic [1:0]        ld_rd,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic [DATA_W-1:0] reg0_out,
  output logic [DATA_W-1:0] reg1_out,
  output logic [DATA_W-1:0] reg2_out,
  output logic [DATA_W-1:0] reg3_out,
  output logic [3:0]        busy,
  output logic              stall
);

  import scpu_pkg::*;

`ifdef REG0_ZERO_EN
  localparam bit ZERO_R0 = 1'b1;
`else
  localparam bit ZERO_R0 = 1'b0;
`endif

  logic [DATA_W-1:0]     r_regs [NUM_REGS];
  logic [NUM_REGS-1:0]   w_busy;
  logic [REG_ADDR_W-1:0] w_pend_rd;
  logic                  w_ld_done;
  ld_state_t             w_state;
  logic                  w_alu_wr;
  logic                  w_ld_wr;

  ld_tracker u_ld_tracker (
    .clk      (clk),
    .rst_n    (rst_n),
    .ld_issue (ld_issue),
    .ld_rd    (ld_rd),
    .ld_valid (ld_valid),
    .ld_ready (ld_ready),
    .busy     (w_busy),
    .pend_rd  (w_pend_rd),
    .ld_done  (w_ld_done),
    .state    (w_state)
  );

  // A stalled request changes nothing; the issuer holds it and retries.
  assign stall    = (alu_we & w_busy[alu_rd]) | (ld_issue & (w_state == WAIT_LD));
  assign w_alu_wr = alu_we & ~w_busy[alu_rd] & ~(ZERO_R0 & (alu_rd == '0));
  assign w_ld_wr  = w_ld_done & ~(ZERO_R0 & (w_pend_rd == '0));

  // ALU and load never collide on one register: the load target is busy for the whole wait.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= (ZERO_R0 && i == 0) ? '0 : RESET_VAL;
      end
    end else begin
      if (w_alu_wr) r_regs[alu_rd] <= alu_data;
      if (w_ld_wr)  r_regs[w_pend_rd] <= ld_data;
    end
  end

  assign reg0_out = r_regs[0];
  assign reg1_out = r_regs[1];
  assign reg2_out = r_regs[2];
  assign reg3_out = r_regs[3];
  assign busy     = w_busy;

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: per-cycle compare against a behavioural model plus directed literal checks.
module tb_reg_file;

  localparam int W = 8;
`ifdef REG0_ZERO_EN
  localparam bit ZERO_R0 = 1'b1;
`else
  localparam bit ZERO_R0 = 1'b0;
`endif

  logic         clk      = 1'b0;
  logic         rst_n    = 1'b0;
  logic         alu_we   = 1'b0;
  logic [1:0]   alu_rd   = '0;
  logic [W-1:0] alu_data = '0;
  logic         ld_issue = 1'b0;
  logic [1:0]   ld_rd    = '0;
  logic         ld_valid = 1'b0;
  logic [W-1:0] ld_data  = '0;
  logic         ld_ready;
  logic [W-1:0] reg0_out, reg1_out, reg2_out, reg3_out;
  logic [3:0]   busy;
  logic         stall;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  reg_file dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .alu_we   (alu_we),
    .alu_rd   (alu_rd),
    .alu_data (alu_data),
    .ld_issue (ld_issue),
    .ld_rd    (ld_rd),
    .ld_valid (ld_valid),
    .ld_data  (ld_data),
    .ld_ready (ld_ready),
    .reg0_out (reg0_out),
    .reg1_out (reg1_out),
    .reg2_out (reg2_out),
    .reg3_out (reg3_out),
    .busy     (busy),
    .stall    (stall)
  );

  // ---------------- behavioural model ----------------
  logic [W-1:0] m_regs [4] = '{default: '0};
  logic [3:0]   m_busy     = '0;
  bit           m_pending  = 1'b0;
  logic [1:0]   m_pend_rd  = '0;

  always @(posedge clk or negedge rst_n) begin : model
    bit acc_alu, ret, iss;
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) m_regs[i] = '0;
      m_busy    = '0;
      m_pending = 1'b0;
      m_pend_rd = '0;
    end else begin
      acc_alu = alu_we && !m_busy[alu_rd];
      ret     = ld_valid && m_pending;
      iss     = ld_issue && !m_pending;
      if (acc_alu && !(ZERO_R0 && alu_rd == 0)) m_regs[alu_rd] = alu_data;
      if (ret) begin
        if (!(ZERO_R0 && m_pend_rd == 0)) m_regs[m_pend_rd] = ld_data;
        m_busy[m_pend_rd] = 1'b0;
        m_pending = 1'b0;
      end
      if (iss) begin
        m_pending = 1'b1;
        m_pend_rd = ld_rd;
        if (!(ZERO_R0 && ld_rd == 0)) m_busy[ld_rd] = 1'b1;
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic cmp(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic lit(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    logic [W-1:0] e;
    exp_q.push_back(exp);
    e = exp_q.pop_front();
    cmp(name, act, e);
  endtask

  always @(negedge clk) begin
    logic exp_stall;
    exp_stall = (alu_we && m_busy[alu_rd]) || (ld_issue && m_pending);
    cmp("model_reg0", reg0_out, m_regs[0]);
    cmp("model_reg1", reg1_out, m_regs[1]);
    cmp("model_reg2", reg2_out, m_regs[2]);
    cmp("model_reg3", reg3_out, m_regs[3]);
    cmp("model_busy", {4'b0, busy}, {4'b0, m_busy});
    cmp("model_ld_ready", {7'b0, ld_ready}, {7'b0, m_pending});
    cmp("model_stall", {7'b0, stall}, {7'b0, exp_stall});
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    alu_we   = 1'b0;
    ld_issue = 1'b0;
    ld_valid = 1'b0;
  endtask

  task automatic drv_alu(input logic [1:0] rd, input logic [W-1:0] d);
    alu_we = 1'b1; alu_rd = rd; alu_data = d;
  endtask

  task automatic drv_issue(input logic [1:0] rd);
    ld_issue = 1'b1; ld_rd = rd;
  endtask

  task automatic drv_ret(input logic [W-1:0] d);
    ld_valid = 1'b1; ld_data = d;
  endtask

  // ---------------- directed vectors ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1;
    lit("rst_reg2", reg2_out, 8'h00);
    lit("rst_busy", {4'b0, busy}, 8'h00);
    lit("rst_ld_ready", {7'b0, ld_ready}, 8'h00);
    rst_n = 1'b1;

    drv_alu(2'd2, 8'h5A); #1;
    lit("alu_stall", {7'b0, stall}, 8'h00);
    tick();
    lit("alu_reg2", reg2_out, 8'h5A);
    lit("alu_reg0", reg0_out, 8'h00);
    lit("alu_reg1", reg1_out, 8'h00);

    drv_issue(2'd1);
    tick();
    for (int i = 0; i < 3; i++) begin
      lit("ld_wait_busy", {4'b0, busy}, 8'h02);
      lit("ld_wait_ready", {7'b0, ld_ready}, 8'h01);
      tick();
    end
    drv_ret(8'hC3);
    tick();
    lit("ld_reg1", reg1_out, 8'hC3);
    lit("ld_busy_clr", {4'b0, busy}, 8'h00);
    lit("ld_ready_clr", {7'b0, ld_ready}, 8'h00);

    drv_issue(2'd1);
    tick();
    drv_alu(2'd1, 8'h77); #1;
    lit("hazard_stall", {7'b0, stall}, 8'h01);
    tick();
    lit("hazard_reg1", reg1_out, 8'hC3);
    drv_alu(2'd3, 8'h11); #1;
    lit("other_stall", {7'b0, stall}, 8'h00);
    tick();
    lit("other_reg3", reg3_out, 8'h11);

    drv_ret(8'hAA);
    drv_alu(2'd3, 8'h55); #1;
    lit("dual_stall", {7'b0, stall}, 8'h00);
    tick();
    lit("dual_reg1", reg1_out, 8'hAA);
    lit("dual_reg3", reg3_out, 8'h55);

    drv_issue(2'd2);
    tick();
    drv_ret(8'h9E);
    drv_issue(2'd3);
    drv_alu(2'd2, 8'h42); #1;
    lit("ret_cycle_stall", {7'b0, stall}, 8'h01);
    tick();
    lit("ret_cycle_reg2", reg2_out, 8'h9E);
    lit("ret_cycle_busy", {4'b0, busy}, 8'h00);
    drv_issue(2'd3);
    drv_alu(2'd2, 8'h42); #1;
    lit("retry_stall", {7'b0, stall}, 8'h00);
    tick();
    lit("retry_reg2", reg2_out, 8'h42);
    lit("retry_busy", {4'b0, busy}, 8'h08);
    drv_ret(8'h33);
    tick();
    lit("retry_ld_reg3", reg3_out, 8'h33);

    drv_alu(2'd2, 8'h5C);
    drv_issue(2'd2); #1;
    lit("same_rd_stall", {7'b0, stall}, 8'h00);
    tick();
    lit("same_rd_alu", reg2_out, 8'h5C);
    lit("same_rd_busy", {4'b0, busy}, 8'h04);
    drv_ret(8'h01);
    tick();
    lit("same_rd_ld", reg2_out, 8'h01);

    drv_ret(8'hEE);
    tick();
    lit("idle_valid_reg2", reg2_out, 8'h01);
    lit("idle_valid_reg3", reg3_out, 8'h33);
    lit("idle_valid_ready", {7'b0, ld_ready}, 8'h00);

    drv_issue(2'd3);
    tick();
    lit("pre_rst_ready", {7'b0, ld_ready}, 8'h01);
    rst_n = 1'b0; #1;
    lit("mid_rst_busy", {4'b0, busy}, 8'h00);
    lit("mid_rst_ready", {7'b0, ld_ready}, 8'h00);
    lit("mid_rst_reg3", reg3_out, 8'h00);
    lit("mid_rst_reg1", reg1_out, 8'h00);
    tick();
    rst_n = 1'b1;
    drv_ret(8'h99);
    tick();
    lit("post_rst_reg3", reg3_out, 8'h00);
    lit("post_rst_busy", {4'b0, busy}, 8'h00);

    drv_alu(2'd0, 8'hFF); #1;
    lit("r0_alu_stall", {7'b0, stall}, 8'h00);
    tick();
`ifdef REG0_ZERO_EN
    lit("r0_alu", reg0_out, 8'h00);
`else
    lit("r0_alu", reg0_out, 8'hFF);
`endif
    drv_issue(2'd0);
    tick();
    lit("r0_ld_ready", {7'b0, ld_ready}, 8'h01);
`ifdef REG0_ZERO_EN
    lit("r0_ld_busy", {4'b0, busy}, 8'h00);
`else
    lit("r0_ld_busy", {4'b0, busy}, 8'h01);
`endif
    drv_ret(8'h77);
    tick();
`ifdef REG0_ZERO_EN
    lit("r0_ld_data", reg0_out, 8'h00);
`else
    lit("r0_ld_data", reg0_out, 8'h77);
`endif
    lit("r0_ld_done_busy", {4'b0, busy}, 8'h00);

    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
